// File: rtl/time_uart_sender_if.sv
// Handshake and data bundle between the ASCII converters and the UART sender.
interface time_uart_sender_if;
  logic        send;
  logic [47:0] ascii_time;
  logic [23:0] ascii_weekday;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output send, ascii_time, ascii_weekday, input tx, busy, done);
  modport slave  (input send, ascii_time, ascii_weekday, output tx, busy, done);
endinterface

// File: rtl/time_uart_sender.sv
// Streams "WWW HH:MM:SS\r\n" as 14 back-to-back 8N1 UART bytes per send pulse.
module time_uart_sender #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                clk,
  input  logic                reset_p,
  time_uart_sender_if.slave   bus
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [BW-1:0]     r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [3:0]        r_byte, w_byte_nxt;
  logic [13:0][7:0]  r_snap;
  logic [13:0][7:0]  w_line;
  logic [7:0]        w_cur;
  logic              r_tx, r_busy, r_done;
  logic              w_tx_nxt, w_busy_nxt, w_done_nxt, w_load, w_wrap;

  // Line image built from the live inputs; byte 0 is the first one on the wire.
  assign w_line = {8'h0A, 8'h0D,
                   bus.ascii_time[7:0],   bus.ascii_time[15:8],  8'h3A,
                   bus.ascii_time[23:16], bus.ascii_time[31:24], 8'h3A,
                   bus.ascii_time[39:32], bus.ascii_time[47:40], 8'h20,
                   bus.ascii_weekday[23:16], bus.ascii_weekday[15:8],
                   bus.ascii_weekday[7:0]};
  assign w_cur  = r_snap[r_byte];
  assign w_wrap = (r_baud == BW'(DIV - 1));

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // State register.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state plus next values of the registered outputs and counters.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    if (r_state != IDLE) w_baud_nxt = w_wrap ? '0 : r_baud + 1'b1;
    case (r_state)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (bus.send) begin
          w_load      = 1'b1;
          w_byte_nxt  = 4'd0;
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = '0;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      START: if (w_wrap) begin
        w_state_nxt = DATA;
        w_bit_nxt   = 3'd0;
        w_tx_nxt    = w_cur[0];
      end
      DATA: if (w_wrap) begin
        if (r_bit == 3'd7) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_bit_nxt = r_bit + 3'd1;
          w_tx_nxt  = w_cur[r_bit + 3'd1];
        end
      end
      STOP: if (w_wrap) begin
        if (r_byte == 4'd13) begin
          // Byte index parks at 13; it is reloaded on the next acceptance.
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_tx_nxt    = 1'b1;
        end else begin
          w_state_nxt = START;
          w_byte_nxt  = r_byte + 4'd1;
          w_tx_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counters, snapshot and registered outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_baud <= '0;
      r_bit  <= '0;
      r_byte <= '0;
      r_snap <= '0;
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_baud <= w_baud_nxt;
      r_bit  <= w_bit_nxt;
      r_byte <= w_byte_nxt;
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_load) r_snap <= w_line;
    end
  end
endmodule

// File: tb/tb_time_uart_sender.sv
// Randomized bench for time_uart_sender: a bit-stream model of the line is
// compared against a mid-bit UART decode of tx.
module tb_time_uart_sender;
  localparam int DIV_S = 10;
  localparam int LINE  = 140 * DIV_S;

  logic clk = 1'b0;
  logic rst_s, rst_d;
  int   vecs = 0;
  int   errs = 0;

  time_uart_sender_if bus_s();
  time_uart_sender_if bus_d();

  time_uart_sender #(.CLK_FREQ(1000), .BAUD(100)) dut_s (.clk(clk), .reset_p(rst_s), .bus(bus_s));
  time_uart_sender dut_d (.clk(clk), .reset_p(rst_d), .bus(bus_d));

  always #5 clk = ~clk;

  // Reference line: weekday letters, space, HH:MM:SS, CR LF.
  function automatic logic [13:0][7:0] model_line(input logic [47:0] t, input logic [23:0] w);
    logic [7:0] q[$];
    logic [13:0][7:0] r;
    for (int i = 0; i < 3; i++) q.push_back(w[8*i +: 8]);
    q.push_back(8'h20);
    for (int d = 0; d < 6; d++) begin
      q.push_back(t[8*(5-d) +: 8]);
      if (d == 1 || d == 3) q.push_back(8'h3A);
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    for (int i = 0; i < 14; i++) r[i] = q[i];
    return r;
  endfunction

  // Pulse send on the small DUT; returns just after the acceptance edge.
  task automatic send_s();
    @(negedge clk);
    bus_s.send = 1'b1;
    @(posedge clk);
    #1 bus_s.send = 1'b0;
  endtask

  // Decode one line. Cycle c is the negedge after acceptance edge + c.
  // se*: edge indices at which send is presented; chg_c: cycle to change ascii_time.
  task automatic capture(input int se0, input int se1, input int se2, input int chg_c,
                         input logic [47:0] chg_val, output logic [13:0][7:0] obs,
                         output int unstable, output int frame_bad, output int ctl_bad,
                         output logic done_ok);
    logic first;
    int slot, ph, bp, by;
    obs = '0; unstable = 0; frame_bad = 0; ctl_bad = 0; done_ok = 1'b0; first = 1'b0;
    for (int c = 0; c <= LINE; c++) begin
      @(negedge clk);
      if (c < LINE) begin
        slot = c / DIV_S; ph = c % DIV_S; bp = slot % 10; by = slot / 10;
        if (ph == 0) first = bus_s.tx;
        else if (bus_s.tx !== first) unstable++;
        if (ph == DIV_S / 2) begin
          if (bp == 0)      begin if (bus_s.tx !== 1'b0) frame_bad++; end
          else if (bp == 9) begin if (bus_s.tx !== 1'b1) frame_bad++; end
          else obs[by][bp-1] = bus_s.tx;
        end
        if (bus_s.busy !== 1'b1 || bus_s.done !== 1'b0) ctl_bad++;
      end else begin
        done_ok = (bus_s.done === 1'b1 && bus_s.busy === 1'b0 && bus_s.tx === 1'b1);
      end
      if (c == chg_c) bus_s.ascii_time = chg_val;
      bus_s.send = (c + 1 == se0) || (c + 1 == se1) || (c + 1 == se2);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_s = 1'b0; rst_d = 1'b0;
    bus_s.send = 1'b0; bus_s.ascii_time = '0; bus_s.ascii_weekday = '0;
    bus_d.send = 1'b0; bus_d.ascii_time = '0; bus_d.ascii_weekday = '0;
    #2 rst_s = 1'b1; rst_d = 1'b1;
    #1;
    vecs++;
    if (bus_s.tx !== 1'b1 || bus_s.busy !== 1'b0 || bus_s.done !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: tx=%b busy=%b done=%b, want 1 0 0", bus_s.tx, bus_s.busy, bus_s.done);
    end
    @(negedge clk) rst_s = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus_s.tx !== 1'b1 || bus_s.busy !== 1'b0 || bus_s.done !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL idle_hold: %0d bad idle cycles, want 0", bad);
    end
  endtask

  task automatic test_single_line();
    logic [13:0][7:0] obs, exp;
    int un, fb, cb;
    logic dok;
    bus_s.ascii_time = 48'h313233343536;
    bus_s.ascii_weekday = 24'h4E4F4D;
    exp = model_line(bus_s.ascii_time, bus_s.ascii_weekday);
    send_s();
    capture(-1, -1, -1, -1, '0, obs, un, fb, cb, dok);
    for (int i = 0; i < 14; i++) begin
      vecs++;
      if (obs[i] !== exp[i]) begin
        errs++;
        $display("FAIL single byte%0d: got %h want %h", i, obs[i], exp[i]);
      end
    end
    vecs++;
    if (un != 0 || fb != 0 || cb != 0 || !dok) begin
      errs++;
      $display("FAIL single_timing: unstable=%0d frame=%0d ctl=%0d done_at_1400=%b, want 0 0 0 1", un, fb, cb, dok);
    end
    @(negedge clk);
    vecs++;
    if (bus_s.done !== 1'b0 || bus_s.busy !== 1'b0 || bus_s.tx !== 1'b1) begin
      errs++;
      $display("FAIL single_after: done=%b busy=%b tx=%b, want 0 0 1", bus_s.done, bus_s.busy, bus_s.tx);
    end
  endtask

  task automatic test_random_lines();
    logic [13:0][7:0] obs, exp;
    logic [23:0] names[7];
    int un, fb, cb;
    logic dok;
    names = '{24'h4E4F4D, 24'h455554, 24'h444557, 24'h554854, 24'h495246, 24'h544153, 24'h4E5553};
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) begin
        for (int d = 0; d < 6; d++) bus_s.ascii_time[8*d +: 8] = 8'h30 + 8'($urandom_range(0, 9));
        bus_s.ascii_weekday = names[$urandom_range(0, 6)];
      end else begin
        bus_s.ascii_time = {16'($urandom), 32'($urandom)};
        bus_s.ascii_weekday = 24'($urandom);
      end
      exp = model_line(bus_s.ascii_time, bus_s.ascii_weekday);
      send_s();
      capture(-1, -1, -1, -1, '0, obs, un, fb, cb, dok);
      for (int i = 0; i < 14; i++) begin
        vecs++;
        if (obs[i] !== exp[i]) begin
          errs++;
          $display("FAIL random%0d byte%0d: got %h want %h", n, i, obs[i], exp[i]);
        end
      end
      vecs++;
      if (un != 0 || fb != 0 || cb != 0 || !dok) begin
        errs++;
        $display("FAIL random%0d_timing: unstable=%0d frame=%0d ctl=%0d done=%b, want 0 0 0 1", n, un, fb, cb, dok);
      end
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
  endtask

  task automatic test_snapshot();
    logic [13:0][7:0] obs, exp;
    int un, fb, cb;
    logic dok;
    bus_s.ascii_time = 48'h313233343536;
    bus_s.ascii_weekday = 24'h455554;
    exp = model_line(bus_s.ascii_time, bus_s.ascii_weekday);
    send_s();
    capture(-1, -1, -1, 50, 48'h393939393939, obs, un, fb, cb, dok);
    for (int i = 0; i < 14; i++) begin
      vecs++;
      if (obs[i] !== exp[i]) begin
        errs++;
        $display("FAIL snapshot byte%0d: got %h want %h", i, obs[i], exp[i]);
      end
    end
    vecs++;
    if (un != 0 || fb != 0 || cb != 0 || !dok) begin
      errs++;
      $display("FAIL snapshot_timing: unstable=%0d frame=%0d ctl=%0d done=%b, want 0 0 0 1", un, fb, cb, dok);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [13:0][7:0] obs, exp;
    int un, fb, cb;
    logic dok;
    bus_s.ascii_time = 48'h303130323033;
    bus_s.ascii_weekday = 24'h444557;
    exp = model_line(bus_s.ascii_time, bus_s.ascii_weekday);
    send_s();
    // Presses at edge 200 (busy) and 1400 (done cycle) must be dropped; 1401 starts line two.
    capture(200, LINE, LINE + 1, -1, '0, obs, un, fb, cb, dok);
    vecs++;
    if (un != 0 || fb != 0 || cb != 0 || !dok || obs !== exp) begin
      errs++;
      $display("FAIL b2b_first: unstable=%0d frame=%0d ctl=%0d done=%b line=%h, want 0 0 0 1 %h", un, fb, cb, dok, obs, exp);
    end
    @(posedge clk);
    #1 bus_s.send = 1'b0;
    capture(-1, -1, -1, -1, '0, obs, un, fb, cb, dok);
    for (int i = 0; i < 14; i++) begin
      vecs++;
      if (obs[i] !== exp[i]) begin
        errs++;
        $display("FAIL b2b_second byte%0d: got %h want %h", i, obs[i], exp[i]);
      end
    end
    vecs++;
    if (un != 0 || fb != 0 || cb != 0 || !dok) begin
      errs++;
      $display("FAIL b2b_second_timing: unstable=%0d frame=%0d ctl=%0d done=%b, want 0 0 0 1", un, fb, cb, dok);
    end
    @(negedge clk);
    vecs++;
    if (bus_s.busy !== 1'b0 || bus_s.tx !== 1'b1) begin
      errs++;
      $display("FAIL b2b_idle: busy=%b tx=%b, want 0 1", bus_s.busy, bus_s.tx);
    end
  endtask

  task automatic test_mid_reset();
    logic [13:0][7:0] obs, exp;
    int un, fb, cb, dones;
    logic dok;
    bus_s.ascii_time = 48'h323334353637;
    bus_s.ascii_weekday = 24'h495246;
    send_s();
    for (int c = 0; c <= 530; c++) @(negedge clk);
    #2 rst_s = 1'b1;
    #1;
    vecs++;
    if (bus_s.tx !== 1'b1 || bus_s.busy !== 1'b0 || bus_s.done !== 1'b0) begin
      errs++;
      $display("FAIL midreset_async: tx=%b busy=%b done=%b, want 1 0 0", bus_s.tx, bus_s.busy, bus_s.done);
    end
    @(negedge clk) rst_s = 1'b0;
    dones = 0;
    for (int c = 0; c < LINE + 20; c++) begin
      @(negedge clk);
      if (bus_s.done !== 1'b0 || bus_s.busy !== 1'b0) dones++;
    end
    vecs++;
    if (dones != 0) begin
      errs++;
      $display("FAIL midreset_quiet: %0d cycles with done/busy, want 0", dones);
    end
    bus_s.ascii_time = 48'h313935393539;
    bus_s.ascii_weekday = 24'h544153;
    exp = model_line(bus_s.ascii_time, bus_s.ascii_weekday);
    send_s();
    capture(-1, -1, -1, -1, '0, obs, un, fb, cb, dok);
    for (int i = 0; i < 14; i++) begin
      vecs++;
      if (obs[i] !== exp[i]) begin
        errs++;
        $display("FAIL midreset_line byte%0d: got %h want %h", i, obs[i], exp[i]);
      end
    end
    vecs++;
    if (un != 0 || fb != 0 || cb != 0 || !dok) begin
      errs++;
      $display("FAIL midreset_timing: unstable=%0d frame=%0d ctl=%0d done=%b, want 0 0 0 1", un, fb, cb, dok);
    end
  endtask

  task automatic test_default_div();
    int low, c;
    logic tx_stop, tx_next, busy_mid;
    @(negedge clk) rst_d = 1'b0;
    bus_d.ascii_weekday = 24'h4E4F4D;   // 'M' has LSB 1, so the start bit ends cleanly
    bus_d.ascii_time = 48'h313233343536;
    @(negedge clk) bus_d.send = 1'b1;
    @(posedge clk);
    #1 bus_d.send = 1'b0;
    low = 0; c = 0;
    while (c < 2000) begin
      @(negedge clk);
      if (bus_d.tx !== 1'b0) break;
      low++; c++;
    end
    vecs++;
    if (low != 868) begin
      errs++;
      $display("FAIL default_start_width: %0d cycles, want 868", low);
    end
    tx_stop = 1'bx; tx_next = 1'bx; busy_mid = 1'bx;
    while (c < 8680) begin
      @(negedge clk);
      c++;
      if (c == 8679) tx_stop = bus_d.tx;
      if (c == 8680) begin tx_next = bus_d.tx; busy_mid = bus_d.busy; end
    end
    vecs++;
    if (tx_stop !== 1'b1 || tx_next !== 1'b0 || busy_mid !== 1'b1) begin
      errs++;
      $display("FAIL default_byte_period: stop=%b next_start=%b busy=%b, want 1 0 1", tx_stop, tx_next, busy_mid);
    end
    #2 rst_d = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_random_lines();
    test_snapshot();
    test_back_to_back();
    test_mid_reset();
    test_default_div();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
